// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state encoding for the shift-add multiplier
package mult_pkg;
    typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} mult_state_t;
endpackage

// File: rtl/add_sub_n.sv
// add_sub_n: N-bit adder/subtractor, subtract by inverting b with carry-in 1
module add_sub_n #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum
);
    assign sum = a + (b ^ {N{sub}}) + N'(sub);
endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential signed/unsigned shift-add multiplier with start/busy/done handshake
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Signed_Mode,
    input  logic [WIDTH-1:0]   Multiplicand,
    input  logic [WIDTH-1:0]   Multiplier,
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] Product,
    output logic               X
);
    localparam int CW = $clog2(WIDTH) + 1;
    mult_state_t state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d, a_q, a_d, b_q, b_d;
    logic [CW-1:0] count_q, count_d;
    logic x_q, x_d, mode_q, mode_d, done_q, done_d;
    logic [WIDTH:0] a_ext, s_ext, sum;
    logic last;
    assign last  = count_q == CW'(WIDTH - 1);
    assign a_ext = {mode_q & a_q[WIDTH-1], a_q};
    assign s_ext = {mode_q & s_q[WIDTH-1], s_q};
    // the final multiplier bit carries negative weight in signed mode
    add_sub_n #(.N(WIDTH + 1)) u_add_sub (
        .a  (a_ext),
        .b  (s_ext),
        .sub(mode_q & last),
        .sum(sum)
    );
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        a_d     = a_q;
        b_d     = b_q;
        x_d     = x_q;
        mode_d  = mode_q;
        count_d = count_q;
        done_d  = state_q == DONE;
        case (state_q)
            IDLE: if (Start) begin
                s_d     = Multiplicand;
                b_d     = Multiplier;
                a_d     = '0;
                x_d     = 1'b0;
                mode_d  = Signed_Mode;
                count_d = '0;
                state_d = ADD;
            end
            ADD: begin
                if (b_q[0]) {x_d, a_d} = sum;
                state_d = SHIFT;
            end
            SHIFT: begin
                {a_d, b_d} = {x_q, a_q, b_q[WIDTH-1:1]};
                x_d        = mode_q & x_q;
                count_d    = count_q + CW'(1);
                state_d    = last ? DONE : ADD;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            x_q     <= 1'b0;
            mode_q  <= 1'b0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            a_q     <= a_d;
            b_q     <= b_d;
            x_q     <= x_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end
    assign Busy    = state_q == ADD || state_q == SHIFT;
    assign Done    = done_q;
    assign Product = {a_q, b_q};
    assign X       = x_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed and random checks at WIDTH 4, 8 and 16
module tb_shift_add_multiplier;
    logic clk = 1'b0;
    logic rst;
    logic st4, sm4, bz4, dn4, x4;
    logic [3:0] a4, b4;
    logic [7:0] p4;
    logic st8, sm8, bz8, dn8, x8;
    logic [7:0] a8, b8;
    logic [15:0] p8;
    logic st16, sm16, bz16, dn16, x16;
    logic [15:0] a16, b16;
    logic [31:0] p16;
    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    shift_add_multiplier #(.WIDTH(4)) dut4 (
        .Clk(clk), .Reset(rst), .Start(st4), .Signed_Mode(sm4), .Multiplicand(a4),
        .Multiplier(b4), .Busy(bz4), .Done(dn4), .Product(p4), .X(x4));
    shift_add_multiplier #(.WIDTH(8)) dut8 (
        .Clk(clk), .Reset(rst), .Start(st8), .Signed_Mode(sm8), .Multiplicand(a8),
        .Multiplier(b8), .Busy(bz8), .Done(dn8), .Product(p8), .X(x8));
    shift_add_multiplier #(.WIDTH(16)) dut16 (
        .Clk(clk), .Reset(rst), .Start(st16), .Signed_Mode(sm16), .Multiplicand(a16),
        .Multiplier(b16), .Busy(bz16), .Done(dn16), .Product(p16), .X(x16));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic st, input logic sg, input logic [15:0] a,
                         input logic [15:0] b);
        if (w == 4) begin st4 = st; sm4 = sg; a4 = a[3:0]; b4 = b[3:0]; end
        else if (w == 8) begin st8 = st; sm8 = sg; a8 = a[7:0]; b8 = b[7:0]; end
        else begin st16 = st; sm16 = sg; a16 = a; b16 = b; end
    endtask

    function automatic logic get_done(input int w);
        return w == 4 ? dn4 : w == 8 ? dn8 : dn16;
    endfunction

    function automatic logic get_busy(input int w);
        return w == 4 ? bz4 : w == 8 ? bz8 : bz16;
    endfunction

    function automatic logic [31:0] get_prod(input int w);
        return w == 4 ? {24'd0, p4} : w == 8 ? {16'd0, p8} : p16;
    endfunction

    function automatic logic get_x(input int w);
        return w == 4 ? x4 : w == 8 ? x8 : x16;
    endfunction

    function automatic logic [31:0] ref_prod(input int w, input logic sg, input logic [15:0] a,
                                             input logic [15:0] b);
        longint va, vb, m;
        m  = (64'd1 << w) - 1;
        va = longint'(a) & m;
        vb = longint'(b) & m;
        if (sg && va[w-1]) va = va - (64'd1 << w);
        if (sg && vb[w-1]) vb = vb - (64'd1 << w);
        return 32'((va * vb) & ((64'd1 << (2 * w)) - 1));
    endfunction

    task automatic run(input int w, input logic sg, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp, input string tag);
        int cyc;
        @(negedge clk);
        drive(w, 1'b1, sg, a, b);
        @(negedge clk);
        drive(w, 1'b0, ~sg, ~a, ~b);
        chk({tag, " busy"}, 64'(get_busy(w)), 64'd1);
        cyc = 0;
        while (!get_done(w) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " latency"}, 64'(cyc), 64'(2 * w + 1));
        chk({tag, " product"}, 64'(get_prod(w)), 64'(exp));
        chk({tag, " x"}, 64'(get_x(w)), 64'(sg & exp[2*w-1]));
        chk({tag, " busy at done"}, 64'(get_busy(w)), 64'd0);
        @(negedge clk);
        chk({tag, " done pulse"}, 64'(get_done(w)), 64'd0);
        chk({tag, " product held"}, 64'(get_prod(w)), 64'(exp));
    endtask

    initial begin
        int cyc, seen;
        logic sg;
        logic [15:0] ra, rb;
        rst = 1'b1;
        drive(4, 1'b0, 1'b0, 16'd0, 16'd0);
        drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
        drive(16, 1'b0, 1'b0, 16'd0, 16'd0);
        repeat (3) @(negedge clk);
        chk("reset product", 64'(p8), 64'd0);
        chk("reset busy", 64'(bz8), 64'd0);
        chk("reset done", 64'(dn8), 64'd0);
        chk("reset x", 64'(x8), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle product", 64'(p8), 64'd0);

        run(8, 1'b1, 16'h07, 16'hFD, 32'hFFEB, "s8 7*-3");
        run(8, 1'b1, 16'h80, 16'h80, 32'h4000, "s8 min*min");
        run(8, 1'b1, 16'hFF, 16'hFF, 32'h0001, "s8 -1*-1");
        run(8, 1'b0, 16'hFF, 16'hFF, 32'hFE01, "u8 max*max");
        run(8, 1'b0, 16'h80, 16'h02, 32'h0100, "u8 128*2");
        run(8, 1'b1, 16'h00, 16'h00, 32'h0000, "s8 zero");
        run(4, 1'b1, 16'h8, 16'h7, 32'hC8, "s4 -8*7");
        run(4, 1'b0, 16'hF, 16'hF, 32'hE1, "u4 max*max");
        run(16, 1'b1, 16'h8000, 16'h8000, 32'h4000_0000, "s16 min*min");
        run(16, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "u16 max*max");

        @(negedge clk);
        drive(8, 1'b1, 1'b0, 16'hFF, 16'hFF);
        @(negedge clk);
        drive(8, 1'b0, 1'b0, 16'hFF, 16'hFF);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset product", 64'(p8), 64'd0);
        chk("midreset busy", 64'(bz8), 64'd0);
        chk("midreset done", 64'(dn8), 64'd0);
        chk("midreset x", 64'(x8), 64'd0);
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (dn8) seen++;
        end
        chk("midreset no done", 64'(seen), 64'd0);

        drive(8, 1'b1, 1'b1, 16'h07, 16'hFD);
        @(negedge clk);
        drive(8, 1'b0, 1'b1, 16'h07, 16'hFD);
        repeat (3) @(negedge clk);
        drive(8, 1'b1, 1'b0, 16'h55, 16'h33);
        @(negedge clk);
        drive(8, 1'b0, 1'b0, 16'h55, 16'h33);
        cyc = 4;
        while (!dn8 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("busy start latency", 64'(cyc), 64'd17);
        chk("busy start product", 64'(p8), 64'hFFEB);
        @(negedge clk);
        chk("busy start not queued", 64'(bz8), 64'd0);
        run(8, 1'b0, 16'h55, 16'h33, 32'h10EF, "u8 after ignore");

        repeat (100) begin
            sg = 1'($urandom_range(1));
            ra = 16'($urandom);
            rb = 16'($urandom);
            run(8, sg, ra, rb, ref_prod(8, sg, ra, rb), "rand8");
        end
        repeat (50) begin
            sg = 1'($urandom_range(1));
            ra = 16'($urandom);
            rb = 16'($urandom);
            run(16, sg, ra, rb, ref_prod(16, sg, ra, rb), "rand16");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
